// File: rtl/out_port_alloc_pkg.sv
// rtl/out_port_alloc_pkg.sv - shared constants for the output-port allocator
package out_port_alloc_pkg;
   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;
   localparam int DEF_CREDITS = 4;
   localparam int CREDIT_W    = 4;
endpackage

// File: rtl/out_port_alloc_if.sv
// rtl/out_port_alloc_if.sv - request/grant/credit bundle between input controllers and one allocator
interface out_port_alloc_if #(
   parameter int NPORT = 5,
   parameter int PORTW = 3
);
   import out_port_alloc_pkg::*;

   logic [NPORT-1:0]       req;
   logic [NPORT*PORTW-1:0] dest;
   logic [NPORT-1:0]       fwdab;
   logic [NPORT-1:0]       tail;
   logic                   credit_in;
   logic [NPORT-1:0]       grt;
   logic [NPORT-1:0]       sel;
   logic [CREDIT_W-1:0]    credit_cnt;
   logic                   busy;
   logic                   wdog_err;

   modport master (
      output req, dest, fwdab, tail, credit_in,
      input  grt, sel, credit_cnt, busy, wdog_err
   );
   modport slave (
      input  req, dest, fwdab, tail, credit_in,
      output grt, sel, credit_cnt, busy, wdog_err
   );
endinterface

// File: rtl/out_port_alloc_rr_arb.sv
// rtl/out_port_alloc_rr_arb.sv - combinational round-robin pick; the pointer lives in the parent
module rr_arb #(
   parameter int NPORT = 5,
   parameter int PTRW  = 3
) (
   input  logic [NPORT-1:0] elig,
   input  logic [PTRW-1:0]  ptr,
   output logic [NPORT-1:0] grt,
   output logic [PTRW-1:0]  win
);
   logic [PTRW:0]   sum;
   logic [PTRW-1:0] idx;
   logic            found;

   always_comb begin
      grt   = '0;
      win   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NPORT; k++) begin
         sum = {1'b0, ptr} + (PTRW+1)'(k);
         if (sum >= (PTRW+1)'(NPORT))
            sum = sum - (PTRW+1)'(NPORT);
         idx = sum[PTRW-1:0];
         if (!found && elig[idx]) begin
            found    = 1'b1;
            grt[idx] = 1'b1;
            win      = idx;
         end
      end
   end
endmodule

// File: rtl/out_port_alloc.sv
// rtl/out_port_alloc.sv - per-output wormhole allocator with credit gating
// Optional stall watchdog: OALLOC_WATCHDOG_EN
module out_port_alloc
   import out_port_alloc_pkg::*;
#(
   parameter int NPORT    = 5,
   parameter int PORTW    = 3,
   parameter int PORTID   = 0,
   parameter int CREDITS  = DEF_CREDITS,
   parameter int WDOG_CYC = 64
) (
   input logic             clk,
   input logic             rst_,
   out_port_alloc_if.slave bus
);
   localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;

   if (NPORT < 2 || NPORT > 16 || CREDITS < 1 || CREDITS > 15 || WDOG_CYC < 1) begin : g_bad_cfg
      $error("out_port_alloc: parameter out of range");
   end

   state_t              state, state_nxt;
   logic [NPORT-1:0]    elig, arb_grt, grt, sel_q;
   logic [PTRW-1:0]     rr_ptr, arb_win;
   logic [CREDIT_W-1:0] credit_q;
   logic                busy_q, credit_ok, xfer, win_tail, wdog_fire;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NPORT; i++)
         elig[i] = bus.req[i] & (bus.fwdab[i] | (bus.dest[i*PORTW +: PORTW] == PORTW'(PORTID)));
   end

   rr_arb #(.NPORT(NPORT), .PTRW(PTRW)) u_arb (
      .elig (elig),
      .ptr  (rr_ptr),
      .grt  (arb_grt),
      .win  (arb_win)
   );

   assign credit_ok = (credit_q != '0);
   assign xfer      = |grt;
   assign win_tail  = |(grt & bus.tail);

   always_ff @(posedge clk) begin
      if (!rst_) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (xfer && !win_tail) state_nxt = S_LOCKED;
         S_LOCKED: if ((xfer && win_tail) || wdog_fire) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Once locked only the owner may move; a dropped owner req is a bubble, not a release
   always_comb begin
      grt = '0;
      if (rst_) begin
         if (state == S_IDLE) begin
            if (credit_ok) grt = arb_grt;
         end else begin
            grt = sel_q & bus.req & {NPORT{credit_ok}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         sel_q    <= '0;
         busy_q   <= 1'b0;
         rr_ptr   <= '0;
         credit_q <= CREDIT_W'(CREDITS);
      end else begin
         busy_q <= (state_nxt == S_LOCKED);
         sel_q  <= (state_nxt == S_LOCKED) ? ((state == S_IDLE) ? grt : sel_q) : '0;
         if (state == S_IDLE && xfer)
            rr_ptr <= (arb_win == PTRW'(NPORT-1)) ? '0 : arb_win + 1'b1;
         case ({xfer, bus.credit_in})
            2'b10:   if (credit_q != '0) credit_q <= credit_q - 1'b1;
            2'b01:   if (credit_q != CREDIT_W'(CREDITS)) credit_q <= credit_q + 1'b1;
            default: credit_q <= credit_q;
         endcase
      end
   end

   // Downstream must never return a credit it was not owed
   always_ff @(posedge clk) begin
      if (rst_)
         assert (!(bus.credit_in && !xfer && credit_q == CREDIT_W'(CREDITS)));
   end

`ifdef OALLOC_WATCHDOG_EN
   localparam int WDW = $clog2(WDOG_CYC + 1);
   logic [WDW-1:0] wdog_cnt;
   logic           wdog_err_q;

   assign wdog_fire = (state == S_LOCKED) && !xfer && (wdog_cnt == WDW'(WDOG_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wdog_cnt   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_err_q <= wdog_fire;
         if (state != S_LOCKED || xfer || wdog_fire) wdog_cnt <= '0;
         else                                        wdog_cnt <= wdog_cnt + 1'b1;
      end
   end
   assign bus.wdog_err = wdog_err_q;
`else
   assign wdog_fire    = 1'b0;
   assign bus.wdog_err = 1'b0;
`endif

   assign bus.grt        = grt;
   assign bus.sel        = sel_q;
   assign bus.busy       = busy_q;
   assign bus.credit_cnt = credit_q;
endmodule
